prbs16_checker: RTL and testbench

//  Receive-side checker for the 16-bit XNOR-feedback PRBS stream produced by our LFSR generators.
//  It self-synchronises to a serial bit stream, predicts each following bit and reports bit errors.
//  It also tracks lock state. It sits at the far end of a link/loopback that the generator drives.

---
 rtl/prbs16_checker.sv | 159 +++++++++++++++
 tb/tb_prbs16_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs16_checker.sv
// Receive-side checker for the 16-bit XNOR-feedback PRBS stream: self-synchronises,
// predicts each following bit, counts bit errors and tracks lock state.
module prbs16_checker #(
    parameter logic [15:0] TAPS       = 16'hD008,
    parameter int          LOCK_COUNT = 32,
    parameter int          WINDOW     = 256,
    parameter int          ERR_THRESH = 8,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear_count,
    output logic             locked,
    output logic             error_pulse,
    output logic             sync_lost,
    output logic [CNT_W-1:0] err_count
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WBIT_W  = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(ERR_THRESH + 1);

    localparam logic [MATCH_W-1:0] MATCH_LIM = MATCH_W'(LOCK_COUNT);
    localparam logic [WBIT_W-1:0]  WBIT_LIM  = WBIT_W'(WINDOW);
    localparam logic [WERR_W-1:0]  WERR_LIM  = WERR_W'(ERR_THRESH);
    localparam logic [15:0]        LOCKUP    = 16'hFFFF;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [15:0]        shadow_q, shadow_d;
    logic [4:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WBIT_W-1:0]  win_bits_q, win_bits_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               sync_lost_q, sync_lost_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               pred;
    logic               err_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign pred = ~^(shadow_q & TAPS);

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_bits_d  = win_bits_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        sync_lost_d = 1'b0;
        err_inc     = 1'b0;

        if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    shadow_d = {shadow_q[14:0], bit_in};
                    if (fill_q == 5'd15) begin
                        fill_d = 5'd0;
                        if (shadow_d != LOCKUP) begin
                            state_d = VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                VERIFY: begin
                    shadow_d = {shadow_q[14:0], bit_in};
                    if (bit_in == pred) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_d == MATCH_LIM) begin
                            state_d    = LOCKED;
                            win_bits_d = '0;
                            win_err_d  = '0;
                        end
                    end else begin
                        state_d = HUNT;
                        fill_d  = 5'd0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a line error cannot corrupt later predictions.
                    shadow_d   = {shadow_q[14:0], pred};
                    win_bits_d = win_bits_q + WBIT_W'(1);
                    if (bit_in != pred) begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        win_err_d   = win_err_q + WERR_W'(1);
                    end
                    if (win_err_d == WERR_LIM) begin
                        state_d     = HUNT;
                        fill_d      = 5'd0;
                        sync_lost_d = 1'b1;
                        win_bits_d  = '0;
                        win_err_d   = '0;
                    end else if (win_bits_d == WBIT_LIM) begin
                        win_bits_d = '0;
                        win_err_d  = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = 5'd0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);

        if (clear_count) begin
            err_count_d = '0;
        end else if (err_inc) begin
            err_count_d = sat_inc(err_count_q);
        end else begin
            err_count_d = err_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= HUNT;
            shadow_q    <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sync_lost_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            sync_lost_q <= sync_lost_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked      = locked_q;
    assign error_pulse = err_pulse_q;
    assign sync_lost   = sync_lost_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed scoreboard bench for prbs16_checker: acquisition, error injection,
// window/threshold behaviour, lockup stream, gapped valid, clear and reset.
module tb_prbs16_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        clear_count = 1'b0;
    logic        locked;
    logic        error_pulse;
    logic        sync_lost;
    logic [31:0] err_count;

    prbs16_checker dut (
        .clk         (clk),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .clear_count (clear_count),
        .locked      (locked),
        .error_pulse (error_pulse),
        .sync_lost   (sync_lost),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        locked;
        logic        pulse;
        logic        sync;
        logic [31:0] cnt;
        logic        chk_locked;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    string       tag = "init";
    logic [15:0] gen = 16'hACE1;
    logic [31:0] cnt_exp = 0;

    // Generator update rule: the emitted bit is the feedback that gets shifted in.
    function automatic logic gen_bit();
        logic fb;
        fb  = ~^(gen & 16'hD008);
        gen = {gen[14:0], fb};
        return fb;
    endfunction

    task automatic check_out();
        exp_t e;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard empty got %0d want >0", tag, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_locked) begin
                n_cmp++;
                assert (locked === e.locked) else begin
                    n_fail++;
                    $error("FAIL %s locked got %b want %b", tag, locked, e.locked);
                end
            end
            n_cmp++;
            assert (error_pulse === e.pulse) else begin
                n_fail++;
                $error("FAIL %s error_pulse got %b want %b", tag, error_pulse, e.pulse);
            end
            n_cmp++;
            assert (sync_lost === e.sync) else begin
                n_fail++;
                $error("FAIL %s sync_lost got %b want %b", tag, sync_lost, e.sync);
            end
            n_cmp++;
            assert (err_count === e.cnt) else begin
                n_fail++;
                $error("FAIL %s err_count got %0d want %0d", tag, err_count, e.cnt);
            end
        end
    endtask

    task automatic send(input logic b, input logic v, input logic clr, input logic el,
                        input logic ep, input logic es, input logic [31:0] ec, input logic cl);
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        bit_in = b;
        bit_valid = v;
        clear_count = clr;
        e.locked = el; e.pulse = ep; e.sync = es; e.cnt = ec; e.chk_locked = cl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        clear_count = 1'b0;
        cnt_exp = 0;
        e.locked = 1'b0; e.pulse = 1'b0; e.sync = 1'b0; e.cnt = 0; e.chk_locked = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic acquire();
        for (int i = 1; i <= 48; i++)
            send(gen_bit(), 1'b1, 1'b0, (i == 48), 1'b0, 1'b0, cnt_exp, 1'b1);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++)
            send(gen_bit(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, cnt_exp, 1'b1);
    endtask

    task automatic inject_err();
        cnt_exp = cnt_exp + 1;
        send(~gen_bit(), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, cnt_exp, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic got;
        int   nv;

        tag = "reset";
        do_reset();

        tag = "clean_acquire";
        acquire();
        clean(9952);

        tag = "single_error";
        inject_err();
        clean(300);

        tag = "eight_errors";
        for (int i = 0; i < 7; i++) inject_err();
        cnt_exp = cnt_exp + 1;
        send(~gen_bit(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, cnt_exp, 1'b1);
        tag = "relock_after_loss";
        acquire();

        tag = "seven_then_one";
        clean(249);
        for (int i = 0; i < 7; i++) inject_err();
        inject_err();
        clean(50);

        tag = "lockup_stream";
        do_reset();
        for (int i = 0; i < 200; i++)
            send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        tag = "lock_after_lockup";
        got = 1'b0;
        for (int k = 0; k < 120 && !got; k++) begin
            send(gen_bit(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            if (locked === 1'b1) got = 1'b1;
        end
        n_cmp++;
        assert (got === 1'b1) else begin
            n_fail++;
            $error("FAIL %s locked_seen got %b want 1", tag, got);
        end
        clean(50);

        tag = "gapped_valid";
        do_reset();
        nv = 0;
        for (int i = 0; i < 96; i++) begin
            if (i % 2 == 0) begin
                nv++;
                send(gen_bit(), 1'b1, 1'b0, (nv >= 48), 1'b0, 1'b0, 32'd0, 1'b1);
            end else begin
                send(1'($urandom_range(0, 1)), 1'b0, 1'b0, (nv >= 48), 1'b0, 1'b0, 32'd0, 1'b1);
            end
        end
        tag = "invalid_ignored";
        for (int i = 0; i < 4; i++)
            send(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cnt_exp, 1'b1);
        clean(5);
        tag = "clear_with_error";
        inject_err();
        clean(3);
        cnt_exp = 0;
        send(~gen_bit(), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, cnt_exp, 1'b1);
        clean(5);

        tag = "reset_while_locked";
        for (int i = 0; i < 5; i++) begin
            inject_err();
            clean(2);
        end
        do_reset();
        tag = "reacquire_after_reset";
        acquire();
        clean(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
